// File: rtl/pipe_mac_if.sv
// Sample/result bundle for pipe_mac: the master drives operands and framing,
// the slave (the MAC) returns framed accumulation results.
interface pipe_mac_if #(
    parameter int AW   = 27,
    parameter int BW   = 19,
    parameter int ACCW = 48
);
    logic            in_valid;
    logic [AW-1:0]   ain;
    logic [BW-1:0]   bin;
    logic            a_signed;
    logic            b_signed;
    logic            acc_first;
    logic            acc_last;
    logic            out_valid;
    logic [ACCW-1:0] acc_out;
    logic            ovf;

    modport master (
        output in_valid, ain, bin, a_signed, b_signed, acc_first, acc_last,
        input  out_valid, acc_out, ovf
    );

    modport slave (
        input  in_valid, ain, bin, a_signed, b_signed, acc_first, acc_last,
        output out_valid, acc_out, ovf
    );
endinterface

// File: rtl/pipe_mac.sv
// Pipelined multiply-accumulate: PIPE-deep multiplier, framed accumulator, sticky overflow.
// Define PIPE_MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module pipe_mac #(
    parameter int AW   = 27,
    parameter int BW   = 19,
    parameter int PIPE = 3,
    parameter int ACCW = 48
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ce,
    pipe_mac_if.slave bus
);
    localparam int PW = AW + BW;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    // Stage 1 holds extended operands; tag[i] is stage i+1; prod[i] is stage i+2.
    logic signed [AW:0]     a_q, a_d;
    logic signed [BW:0]     b_q, b_d;
    tag_t                   tag_q  [PIPE];
    tag_t                   tag_d  [PIPE];
    logic signed [PW-1:0]   prod_q [PIPE-1];
    logic signed [PW-1:0]   prod_d [PIPE-1];

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   sticky_q, sticky_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACCW-1:0]        acc_out_q, acc_out_d;
    logic                   ovf_q, ovf_d;

    tag_t                   acc_tag;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] sum;
    logic                   add_ovf;

    always_comb begin
        a_d = bus.a_signed ? {bus.ain[AW-1], bus.ain} : {1'b0, bus.ain};
        b_d = bus.b_signed ? {bus.bin[BW-1], bus.bin} : {1'b0, bus.bin};

        tag_d[0] = '{vld:   bus.in_valid,
                     first: bus.in_valid & bus.acc_first,
                     last:  bus.in_valid & bus.acc_last};
        for (int i = 1; i < PIPE; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // Both operands fit in PW bits once extended, so a PW-wide product is the exact truncation.
        prod_d[0] = PW'(a_q) * PW'(b_q);
        for (int i = 1; i < PIPE - 1; i++) begin
            prod_d[i] = prod_q[i-1];
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path infers a latch.
        acc_tag     = tag_q[PIPE-1];
        prod_ext    = ACCW'(prod_q[PIPE-2]);
        sum         = acc_q + prod_ext;
        add_ovf     = (acc_q[ACCW-1] == prod_ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);

        acc_d       = acc_q;
        sticky_d    = sticky_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        if (acc_tag.vld) begin
            if (acc_tag.first) begin
                acc_d    = prod_ext;
                sticky_d = 1'b0;
            end else begin
                acc_d    = sum;
                sticky_d = sticky_q | add_ovf;
`ifdef PIPE_MAC_SAT_EN
                // Same-sign overflow: the accumulator's sign gives the clamp direction.
                if (add_ovf) begin
                    acc_d = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                          : {1'b0, {(ACCW-1){1'b1}}};
                end
`endif
            end
            if (acc_tag.last) begin
                acc_out_d   = acc_d;
                ovf_d       = sticky_d;
                out_valid_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the pipeline storage is reset too, so a reset flushes in-flight samples.
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < PIPE - 1; i++) begin
                prod_q[i] <= '0;
            end
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_mac.sv
// Self-checking bench for pipe_mac: directed table, framed sequences and a random run
// compared against a frame-level arithmetic model.
module tb_pipe_mac;
    localparam int AW   = 27;
    localparam int BW   = 19;
    localparam int PIPE = 3;
    localparam int ACCW = 48;
    localparam int PW   = AW + BW;
    localparam longint ACC_MAX = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACCW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    pipe_mac_if #(.AW(AW), .BW(BW), .ACCW(ACCW)) bus ();

    pipe_mac #(.AW(AW), .BW(BW), .PIPE(PIPE), .ACCW(ACCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        bit            as;
        bit            bs;
        longint        exp_acc;
        bit            exp_ovf;
    } vec_t;

    typedef struct {
        int     due;
        longint acc;
        bit     ovf;
    } res_t;

    // Reference model: running sum in plain integer arithmetic plus a queue of
    // results due a fixed number of ce edges after their last sample.
    longint m_acc;
    bit     m_ovf;
    int     ce_cnt;
    res_t   exp_q[$];
    bit     exp_ov;
    longint exp_acc;
    bit     exp_ovf;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_prod(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input bit as, input bit bs);
        longint av, bv, p;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return (p <<< (64 - PW)) >>> (64 - PW);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_acc   = 0;
        m_ovf   = 1'b0;
        exp_ov  = 1'b0;
        exp_acc = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                              input bit as, input bit bs, input bit f, input bit l);
        longint p, s;
        res_t   r;
        ce_cnt++;
        if (v) begin
            p = model_prod(a, b, as, bs);
            if (f) begin
                m_acc = p;
                m_ovf = 1'b0;
            end else begin
                s = m_acc + p;
                if (s > ACC_MAX || s < ACC_MIN) begin
                    m_ovf = 1'b1;
`ifdef PIPE_MAC_SAT_EN
                    s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
                    s = (s <<< (64 - ACCW)) >>> (64 - ACCW);
`endif
                end
                m_acc = s;
            end
            if (l) exp_q.push_back('{due: ce_cnt + PIPE, acc: m_acc, ovf: m_ovf});
        end
        exp_ov = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == ce_cnt) begin
            r       = exp_q.pop_front();
            exp_ov  = 1'b1;
            exp_acc = r.acc;
            exp_ovf = r.ovf;
        end
    endtask

    // Called at a negedge; drives one cycle, then compares the DUT with the model at the next negedge.
    task automatic step(input bit c, input bit v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input bit as, input bit bs, input bit f, input bit l);
        ce            = c;
        bus.in_valid  = v;
        bus.ain       = a;
        bus.bin       = b;
        bus.a_signed  = as;
        bus.b_signed  = bs;
        bus.acc_first = f;
        bus.acc_last  = l;
        @(posedge clk);
        if (c) model_edge(v, a, b, as, bs, f, l);
        @(negedge clk);
        check("model_out_valid", bus.out_valid, exp_ov);
        check("model_acc_out", $signed(bus.acc_out), exp_acc);
        check("model_ovf", bus.ovf, exp_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sample(input longint a, input longint b, input bit f, input bit l);
        step(1'b1, 1'b1, AW'(a), BW'(b), 1'b1, 1'b1, f, l);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_acc_out", $signed(bus.acc_out), 0);
        check("reset_ovf", bus.ovf, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[6];
        longint ovf_exp;

        tbl[0] = '{AW'(-3),      BW'(5),        1'b1, 1'b1, -15,                    1'b0};
        tbl[1] = '{27'h7FFFFFF,  BW'(-2),       1'b0, 1'b1, -268435454,             1'b0};
        tbl[2] = '{27'h7FFFFFF,  BW'(-2),       1'b1, 1'b1, 2,                      1'b0};
        tbl[3] = '{AW'(100),     BW'(200),      1'b0, 1'b0, 20000,                  1'b0};
        tbl[4] = '{27'h4000000,  19'h7FFFF,     1'b1, 1'b0, -64'sd35184304979968,   1'b0};
        tbl[5] = '{AW'(1),       19'h40000,     1'b1, 1'b1, -262144,                1'b0};

        ce_cnt = 0;
        model_clear();
        bus.in_valid  = 1'b0;
        bus.ain       = '0;
        bus.bin       = '0;
        bus.a_signed  = 1'b0;
        bus.b_signed  = 1'b0;
        bus.acc_first = 1'b0;
        bus.acc_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("por_out_valid", bus.out_valid, 0);
        check("por_acc_out", $signed(bus.acc_out), 0);
        check("por_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        idle(2);

        // Single-sample frames: no result for PIPE edges, then the product on edge PIPE+1.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].bs, 1'b1, 1'b1);
            check("tbl_early_valid", bus.out_valid, 0);
            for (int k = 1; k < PIPE; k++) begin
                idle(1);
                check("tbl_early_valid", bus.out_valid, 0);
            end
            idle(1);
            check("tbl_out_valid", bus.out_valid, 1);
            check("tbl_acc_out", $signed(bus.acc_out), tbl[i].exp_acc);
            check("tbl_ovf", bus.ovf, tbl[i].exp_ovf);
            idle(1);
        end

        // Dot product followed back-to-back by a single-sample frame.
        sample(2, 3, 1'b1, 1'b0);
        sample(-4, 5, 1'b0, 1'b0);
        sample(6, -7, 1'b0, 1'b0);
        sample(1, 1, 1'b0, 1'b1);
        sample(10, 10, 1'b1, 1'b1);
        idle(PIPE - 1);
        check("dot_out_valid", bus.out_valid, 1);
        check("dot_acc_out", $signed(bus.acc_out), -55);
        idle(1);
        check("b2b_out_valid", bus.out_valid, 1);
        check("b2b_acc_out", $signed(bus.acc_out), 100);
        idle(1);
        check("b2b_pulse_end", bus.out_valid, 0);

        // Same frame with ce low for three cycles after sample 2, valid still asserted.
        sample(2, 3, 1'b1, 1'b0);
        sample(-4, 5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, AW'(6), BW'(-7), 1'b1, 1'b1, 1'b0, 1'b0);
        sample(6, -7, 1'b0, 1'b0);
        sample(1, 1, 1'b0, 1'b1);
        idle(PIPE - 1);
        check("gate_not_yet", bus.out_valid, 0);
        idle(1);
        check("gate_out_valid", bus.out_valid, 1);
        check("gate_acc_out", $signed(bus.acc_out), -55);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("gate_hold_valid", bus.out_valid, 1);
        idle(1);
        check("gate_pulse_end", bus.out_valid, 0);

        // Nine products of 2^44 overflow the 48-bit accumulator.
`ifdef PIPE_MAC_SAT_EN
        ovf_exp = (longint'(1) <<< 47) - 1;
`else
        ovf_exp = -(longint'(1) <<< 47) + (longint'(1) <<< 44);
`endif
        for (int k = 1; k <= 9; k++) sample(-(longint'(1) <<< 26), -(longint'(1) <<< 18), k == 1, k == 9);
        idle(PIPE);
        check("ovf_out_valid", bus.out_valid, 1);
        check("ovf_acc_out", $signed(bus.acc_out), ovf_exp);
        check("ovf_flag", bus.ovf, 1);
        idle(1);

        // Reset mid-frame discards the partial sum; the next frame starts clean.
        sample(2, 3, 1'b1, 1'b0);
        sample(-4, 5, 1'b0, 1'b0);
        do_reset();
        idle(PIPE + 2);
        check("post_reset_quiet", bus.out_valid, 0);
        sample(7, 6, 1'b1, 1'b1);
        idle(PIPE);
        check("post_reset_valid", bus.out_valid, 1);
        check("post_reset_acc", $signed(bus.acc_out), 42);
        check("post_reset_ovf", bus.ovf, 0);
        idle(1);

        // Random traffic: gaps, ce stalls, mixed signs, open-ended running sums.
        for (int n = 0; n < 500; n++) begin
            bit            c, v;
            logic [AW-1:0] a;
            logic [BW-1:0] b;
            c = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a = AW'($urandom());
                b = BW'($urandom());
            end else begin
                a = AW'($urandom_range(0, 2000)) - AW'(1000);
                b = BW'($urandom_range(0, 2000)) - BW'(1000);
            end
            step(c, v, a, b, 1'($urandom()), 1'($urandom()),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        idle(PIPE + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
